// File: rtl/array2d_pkg.sv
// Shared types for the 2D array scan reader.
// Scan FSM state enum and the index-width helper.
package array2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/array2d_scan_reader_if.sv
// Output stream bundle of the scan reader.
// valid/ready handshake plus data, row, col, last.
interface array2d_scan_reader_if #(
  parameter int W  = 8,
  parameter int RW = 2,
  parameter int CW = 2
);

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/array2d_store.sv
// ROWS x COLS cell array: range-checked write port,
// combinational read port with same-edge write bypass.
module array2d_store
  import array2d_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  parameter  int W    = 8,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [W-1:0]  wr_data,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [ROWS][COLS];
  logic         wr_ok;

  // indices beyond the array are dropped
  assign wr_ok = wr_en
              && (int'(wr_row) < ROWS)
              && (int'(wr_col) < COLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (wr_ok
              && wr_row == RW'(r)
              && wr_col == CW'(c))
            mem[r][c] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rd_row == RW'(r) && rd_col == CW'(c))
          rd_data = mem[r][c];
    // a write landing on the cell being read wins
    if (wr_ok && wr_row == rd_row && wr_col == rd_col)
      rd_data = wr_data;
  end

endmodule

// File: rtl/array2d_scan_reader.sv
// Streams a ROWS x COLS array out in row-major order.
// Ports: clk, rst_n, write port, start/busy/done, os stream.
module array2d_scan_reader
  import array2d_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  parameter  int W    = 8,
  localparam int RW   = idx_w(ROWS),
  localparam int CW   = idx_w(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_row,
  input  logic [CW-1:0]         wr_col,
  input  logic [W-1:0]          wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  array2d_scan_reader_if.master os
);

  localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

  scan_state_e   state_q;
  scan_state_e   state_d;
  logic          hs;
  logic          load;
  logic          fin;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [W-1:0]  rd_data;

  assign hs = os.out_valid && os.out_ready;

  array2d_store #(
    .ROWS(ROWS),
    .COLS(COLS),
    .W   (W)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_data(wr_data),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (hs && os.out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_row/rd_col select the cell loaded on this edge
  always_comb begin
    load   = 1'b0;
    fin    = 1'b0;
    rd_row = '0;
    rd_col = '0;
    busy   = (state_q == SCAN);
    done   = (state_q == DONE);
    unique case (1'b1)
      (state_q == IDLE) && start: begin
        load = 1'b1;
      end
      (state_q == SCAN) && hs && !os.out_last: begin
        load = 1'b1;
        if (os.out_col == LAST_C) begin
          rd_row = os.out_row + 1'b1;
        end else begin
          rd_row = os.out_row;
          rd_col = os.out_col + 1'b1;
        end
      end
      (state_q == SCAN) && hs && os.out_last: begin
        fin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os.out_valid <= 1'b0;
      os.out_data  <= '0;
      os.out_row   <= '0;
      os.out_col   <= '0;
      os.out_last  <= 1'b0;
    end else if (load) begin
      os.out_valid <= 1'b1;
      os.out_data  <= rd_data;
      os.out_row   <= rd_row;
      os.out_col   <= rd_col;
      os.out_last  <= (rd_row == LAST_R)
                   && (rd_col == LAST_C);
    end else if (fin) begin
      os.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_array2d_scan_reader.sv
// Self-checking bench for array2d_scan_reader.
// 4x4x8 instance plus a 1x1x1 instance.
module tb_array2d_scan_reader;
  import array2d_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0;
  logic [1:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;

  array2d_scan_reader_if #(.W(8), .RW(2), .CW(2)) sif();

  array2d_scan_reader #(.ROWS(4), .COLS(4), .W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_data(wr_data),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .os     (sif)
  );

  logic s_wr_en = 1'b0;
  logic s_wr_row = 1'b0;
  logic s_wr_col = 1'b0;
  logic s_wr_data = 1'b0;
  logic s_start = 1'b0;
  logic s_busy;
  logic s_done;

  array2d_scan_reader_if #(.W(1), .RW(1), .CW(1)) sif1();

  array2d_scan_reader #(.ROWS(1), .COLS(1), .W(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (s_wr_en),
    .wr_row (s_wr_row),
    .wr_col (s_wr_col),
    .wr_data(s_wr_data),
    .start  (s_start),
    .busy   (s_busy),
    .done   (s_done),
    .os     (sif1)
  );

  typedef struct {
    int         beat;
    int         idx;
    logic [7:0] d;
  } wev_t;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] mdl [16];
  wev_t       evq [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_cell(input int r, input int c,
                         input logic [7:0] d);
    wr_en = 1'b1;
    wr_row = 2'(r);
    wr_col = 2'(c);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    mdl[r*4+c] = d;
  endtask

  // mode 0: ready always, 1: random, 2: 1,0,0,1 pattern
  task automatic run_scan(input int mode,
                          input int start_mid,
                          input bit stall_wr);
    logic [7:0] exp [16];
    int         k;
    int         cyc;
    int         rdy_i;
    bit         stalled;
    bit         rdy;
    logic [7:0] sd;
    logic [1:0] sr;
    logic [1:0] sc;
    logic       sl;
    wev_t       ev;
    k = 0;
    cyc = 0;
    rdy_i = 0;
    stalled = 1'b0;
    for (int i = 0; i < 16; i++) exp[i] = mdl[i];
    sif.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_latency_valid", 32'(sif.out_valid), 1);
    chk("busy_in_scan", 32'(busy), 1);
    while (k < 16 && cyc < 400) begin
      wr_en = 1'b0;
      start = 1'b0;
      if (stalled) begin
        chk("stall_data", 32'(sif.out_data), 32'(sd));
        chk("stall_row", 32'(sif.out_row), 32'(sr));
        chk("stall_col", 32'(sif.out_col), 32'(sc));
        chk("stall_last", 32'(sif.out_last), 32'(sl));
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (rdy_i % 4 == 0) || (rdy_i % 4 == 3);
      endcase
      rdy_i++;
      sif.out_ready = rdy;
      if (sif.out_valid && rdy) begin
        chk("beat_data", 32'(sif.out_data), 32'(exp[k]));
        chk("beat_row", 32'(sif.out_row), k / 4);
        chk("beat_col", 32'(sif.out_col), k % 4);
        chk("beat_last", 32'(sif.out_last), 32'(k == 15));
        if (evq.size() > 0 && evq[0].beat == k) begin
          ev = evq.pop_front();
          wr_en = 1'b1;
          wr_row = 2'(ev.idx / 4);
          wr_col = 2'(ev.idx % 4);
          wr_data = ev.d;
          mdl[ev.idx] = ev.d;
          if (ev.idx > k) exp[ev.idx] = ev.d;
        end
        if (k == start_mid) start = 1'b1;
        k++;
        stalled = 1'b0;
      end else if (sif.out_valid) begin
        stalled = 1'b1;
        sd = sif.out_data;
        sr = sif.out_row;
        sc = sif.out_col;
        sl = sif.out_last;
        if (stall_wr) begin
          wr_en = 1'b1;
          wr_row = sif.out_row;
          wr_col = sif.out_col;
          wr_data = ~sif.out_data;
          mdl[k] = ~sif.out_data;
        end
      end else begin
        chk("no_bubble", 32'(sif.out_valid), 1);
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    start = 1'b0;
    sif.out_ready = 1'b0;
    chk("beat_count", k, 16);
    chk("done_pulse", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("valid_after_last", 32'(sif.out_valid), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_valid", 32'(sif.out_valid), 0);
    tick();
    chk("no_restart_valid", 32'(sif.out_valid), 0);
    chk("no_restart_busy", 32'(busy), 0);
  endtask

  initial begin
    sif.out_ready = 1'b0;
    sif1.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    tick();
    tick();
    chk("rst_valid", 32'(sif.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(sif.out_data), 0);
    chk("rst_last", 32'(sif.out_last), 0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a scan
    for (int i = 0; i < 16; i++)
      wr_cell(i / 4, i % 4, 8'($urandom_range(1, 255)));
    start = 1'b1;
    tick();
    start = 1'b0;
    sif.out_ready = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(sif.out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    @(negedge clk);
    sif.out_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_abort_done", 32'(done), 0);
    run_scan(0, -1, 1'b0);

    // 16*r+c pattern, full throughput
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wr_cell(r, c, 8'(16 * r + c));
    run_scan(0, -1, 1'b0);

    // stalls with writes to the presented cell
    run_scan(2, -1, 1'b1);
    run_scan(1, -1, 1'b0);

    // writes during a scan, ahead of / behind / onto the load
    evq.push_back('{beat: 3, idx: 9, d: 8'hAA});
    evq.push_back('{beat: 5, idx: 0, d: 8'h55});
    evq.push_back('{beat: 6, idx: 7, d: 8'h77});
    run_scan(0, -1, 1'b0);
    chk("events_consumed", evq.size(), 0);
    run_scan(0, -1, 1'b0);

    // random contents, random ready, start while busy
    for (int i = 0; i < 16; i++)
      wr_cell(i / 4, i % 4, 8'($urandom));
    run_scan(1, 4, 1'b0);

    // 1x1 instance with out-of-range writes
    s_wr_en = 1'b1;
    s_wr_data = 1'b1;
    tick();
    s_wr_data = 1'b0;
    s_wr_row = 1'b1;
    s_wr_col = 1'b0;
    tick();
    s_wr_row = 1'b0;
    s_wr_col = 1'b1;
    tick();
    s_wr_row = 1'b1;
    tick();
    s_wr_en = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    chk("one_valid", 32'(sif1.out_valid), 1);
    chk("one_data", 32'(sif1.out_data), 1);
    chk("one_last", 32'(sif1.out_last), 1);
    chk("one_busy", 32'(s_busy), 1);
    sif1.out_ready = 1'b1;
    tick();
    sif1.out_ready = 1'b0;
    chk("one_valid_off", 32'(sif1.out_valid), 0);
    chk("one_done", 32'(s_done), 1);
    chk("one_busy_off", 32'(s_busy), 0);
    tick();
    chk("one_done_once", 32'(s_done), 0);
    chk("one_idle_valid", 32'(sif1.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
